// File: rtl/manta_run_ctrl.sv
// manta_run_ctrl: streams a program into imem, holds the core at PC 0,
// then runs it until the core halts or the cycle budget runs out.
module manta_run_ctrl #(
    parameter int HOLD_CYCLES = 10,
    parameter int MAX_CYCLES  = 1000,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [15:0]       load_data,
    input  logic              load_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              core_hold,
    input  logic              core_halt,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              load_ovf,
    output logic [31:0]       cycle_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN,
        DONE
    } state_t;

    // A zero hold length still needs one cycle of PC-0 hold.
    localparam int          HOLD_EFF  = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_EFF - 1);
    localparam logic [31:0] MAX_CNT   = 32'(MAX_CYCLES);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [31:0]       hold_cnt;
    logic [31:0]       cnt_inc;
    logic              xfer;
    logic              launch;
    logic              hold_end;
    logic              budget_hit;

    assign xfer       = load_valid && load_ready;
    assign launch     = start && (state == IDLE || state == DONE);
    assign hold_end   = (hold_cnt == HOLD_LAST);
    assign cnt_inc    = (&cycle_count) ? cycle_count : cycle_count + 32'd1;
    assign budget_hit = (cnt_inc >= MAX_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = LOAD;
            DONE:    if (start) state_nxt = LOAD;
            LOAD:    if (xfer && load_last) state_nxt = HOLD;
            HOLD:    if (hold_end) state_nxt = RUN;
            RUN:     if (core_halt || budget_hit) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_ready = 1'b0;
        core_hold  = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            LOAD: begin
                load_ready = 1'b1;
                busy       = 1'b1;
            end
            HOLD: busy = 1'b1;
            RUN: begin
                core_hold = 1'b0;
                busy      = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign imem_we    = xfer;
    assign imem_addr  = wr_ptr;
    assign imem_wdata = xfer ? load_data : 16'h0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            hold_cnt    <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            load_ovf    <= 1'b0;
        end else begin
            if (launch) begin
                wr_ptr      <= '0;
                cycle_count <= '0;
                timeout     <= 1'b0;
                load_ovf    <= 1'b0;
            end
            if (xfer) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (&wr_ptr && !load_last) load_ovf <= 1'b1;
            end
            hold_cnt <= (state == HOLD) ? hold_cnt + 32'd1 : 32'd0;
            // Halt wins over budget exhaustion in the same cycle.
            if (state == RUN) begin
                cycle_count <= cnt_inc;
                if (!core_halt && budget_hit) timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_manta_run_ctrl.sv
// tb_manta_run_ctrl: randomized load/hold/run sequences checked against
// expectations derived from the sequencing rules, plus a narrow-address DUT.
module tb_manta_run_ctrl;

    localparam int A_HOLD = 10;
    localparam int A_MAX  = 1000;
    localparam int B_MAX  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_start, a_valid, a_last, a_halt;
    logic [15:0] a_data;
    logic        a_ready, a_we, a_hold, a_busy, a_done, a_to, a_ovf;
    logic [15:0] a_addr, a_wdata;
    logic [31:0] a_cnt;

    logic        b_rst, b_start, b_valid, b_last, b_halt;
    logic [15:0] b_data;
    logic        b_ready, b_we, b_hold, b_busy, b_done, b_to, b_ovf;
    logic [1:0]  b_addr;
    logic [15:0] b_wdata;
    logic [31:0] b_cnt;

    int vectors = 0;
    int miscompares = 0;

    manta_run_ctrl #(
        .HOLD_CYCLES(A_HOLD),
        .MAX_CYCLES (A_MAX),
        .ADDR_W     (16)
    ) u_a (
        .clk        (clk),
        .rst        (a_rst),
        .start      (a_start),
        .load_valid (a_valid),
        .load_ready (a_ready),
        .load_data  (a_data),
        .load_last  (a_last),
        .imem_we    (a_we),
        .imem_addr  (a_addr),
        .imem_wdata (a_wdata),
        .core_hold  (a_hold),
        .core_halt  (a_halt),
        .busy       (a_busy),
        .done       (a_done),
        .timeout    (a_to),
        .load_ovf   (a_ovf),
        .cycle_count(a_cnt)
    );

    manta_run_ctrl #(
        .HOLD_CYCLES(0),
        .MAX_CYCLES (B_MAX),
        .ADDR_W     (2)
    ) u_b (
        .clk        (clk),
        .rst        (b_rst),
        .start      (b_start),
        .load_valid (b_valid),
        .load_ready (b_ready),
        .load_data  (b_data),
        .load_last  (b_last),
        .imem_we    (b_we),
        .imem_addr  (b_addr),
        .imem_wdata (b_wdata),
        .core_hold  (b_hold),
        .core_halt  (b_halt),
        .busy       (b_busy),
        .done       (b_done),
        .timeout    (b_to),
        .load_ovf   (b_ovf),
        .cycle_count(b_cnt)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic edge_a();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_checks_a(string tag);
        chk({tag, "_hold"}, a_hold, 1);
        chk({tag, "_ready"}, a_ready, 0);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_done"}, a_done, 0);
        chk({tag, "_to"}, a_to, 0);
        chk({tag, "_ovf"}, a_ovf, 0);
        chk({tag, "_addr"}, a_addr, 0);
        chk({tag, "_cnt"}, a_cnt, 0);
        chk({tag, "_we"}, a_we, 0);
    endtask

    // Full load/hold/run sequence on DUT A. halt_at/rst_at: run cycle
    // (1-based) to assert halt/reset, 0 for never.
    task automatic run_a(int n, bit gaps, bit pat, int halt_at, int rst_at);
        logic [15:0] w;
        int i, guard, c, exp_cnt;
        bit fin, exp_to;
        a_start = 1;
        a_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("launch_ready", a_ready, 0);
        chk("launch_we", a_we, 0);
        chk("launch_hold", a_hold, 1);
        edge_a();
        i = 0;
        guard = 0;
        while (i < n && guard < 20 * n + 20) begin
            a_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            a_start = ($urandom_range(0, 3) == 0);
            w = pat ? 16'(16'h1111 * (i + 1)) : 16'($urandom);
            a_data = w;
            a_last = (i == n - 1);
            @(negedge clk);
            chk("ld_ready", a_ready, 1);
            chk("ld_busy", a_busy, 1);
            chk("ld_we", a_we, a_valid);
            if (a_valid) begin
                chk("ld_addr", a_addr, i);
                chk("ld_data", a_wdata, w);
            end
            edge_a();
            if (a_valid) i++;
            guard++;
        end
        chk("ld_words", i, n);
        a_last = 0;
        for (int k = 0; k < A_HOLD; k++) begin
            a_valid = 1'($urandom_range(0, 1));
            a_start = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("hd_hold", a_hold, 1);
            chk("hd_ready", a_ready, 0);
            chk("hd_we", a_we, 0);
            chk("hd_busy", a_busy, 1);
            chk("hd_cnt", a_cnt, 0);
            edge_a();
        end
        c = 1;
        fin = 0;
        while (!fin) begin
            a_halt = (c == halt_at);
            a_rst = (c == rst_at);
            a_start = 1'($urandom_range(0, 1));
            a_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rn_hold", a_hold, 0);
            chk("rn_cnt", a_cnt, c - 1);
            chk("rn_we", a_we, 0);
            edge_a();
            if (a_rst) begin
                a_rst = 0;
                a_halt = 0;
                a_start = 0;
                a_valid = 0;
                @(negedge clk);
                idle_checks_a("rst");
                edge_a();
                return;
            end
            if (a_halt || c >= A_MAX) fin = 1;
            c++;
        end
        a_halt = 0;
        a_start = 0;
        exp_to = !(halt_at >= 1 && halt_at <= A_MAX);
        exp_cnt = exp_to ? A_MAX : halt_at;
        for (int k = 0; k < 3; k++) begin
            a_valid = 1'($urandom_range(0, 1));
            a_halt = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("dn_done", a_done, 1);
            chk("dn_to", a_to, exp_to);
            chk("dn_cnt", a_cnt, exp_cnt);
            chk("dn_hold", a_hold, 1);
            chk("dn_busy", a_busy, 0);
            chk("dn_we", a_we, 0);
            chk("dn_ovf", a_ovf, 0);
            edge_a();
        end
        a_halt = 0;
        a_valid = 0;
    endtask

    // Gap-free sequence on the 2-bit-address, zero-hold DUT B.
    task automatic run_b(int n, int halt_at);
        int c, exp_cnt;
        bit fin, exp_to;
        b_start = 1;
        edge_a();
        b_start = 0;
        for (int i = 0; i < n; i++) begin
            b_valid = 1;
            b_data = 16'(16'h00A0 + i);
            b_last = (i == n - 1);
            @(negedge clk);
            chk("b_we", b_we, 1);
            chk("b_addr", b_addr, i % 4);
            chk("b_data", b_wdata, 16'h00A0 + i);
            edge_a();
        end
        b_valid = 0;
        b_last = 0;
        @(negedge clk);
        chk("b_hd_hold", b_hold, 1);
        chk("b_hd_busy", b_busy, 1);
        chk("b_ovf", b_ovf, (n > 4));
        edge_a();
        c = 1;
        fin = 0;
        while (!fin) begin
            b_halt = (c == halt_at);
            @(negedge clk);
            chk("b_rn_hold", b_hold, 0);
            edge_a();
            if (b_halt || c >= B_MAX) fin = 1;
            c++;
        end
        b_halt = 0;
        exp_to = !(halt_at >= 1 && halt_at <= B_MAX);
        exp_cnt = exp_to ? B_MAX : halt_at;
        @(negedge clk);
        chk("b_done", b_done, 1);
        chk("b_to", b_to, exp_to);
        chk("b_cnt", b_cnt, exp_cnt);
        chk("b_ovf_kept", b_ovf, (n > 4));
        edge_a();
    endtask

    initial begin
        int n;
        a_rst = 1; a_start = 1; a_valid = 1; a_last = 0; a_halt = 1;
        a_data = 16'h0;
        b_rst = 1; b_start = 0; b_valid = 0; b_last = 0; b_halt = 0;
        b_data = 16'h0;
        edge_a();
        edge_a();
        a_start = 0; a_valid = 0; a_halt = 0;
        a_rst = 0;
        b_rst = 0;
        @(negedge clk);
        idle_checks_a("reset");
        chk("b_reset_hold", b_hold, 1);
        chk("b_reset_cnt", b_cnt, 0);
        edge_a();

        run_a(4, 0, 1, 25, 0);
        run_a(int'($urandom_range(1, 12)), 1, 0, 0, 0);
        run_a(int'($urandom_range(2, 12)), 1, 0, 20, 7);
        run_a(int'($urandom_range(1, 12)), 1, 0, 3, 0);
        run_a(3, 0, 0, A_MAX, 0);
        for (int t = 0; t < 6; t++) begin
            n = int'($urandom_range(1, 24));
            run_a(n, 1'($urandom_range(0, 1)), 0,
                  int'($urandom_range(1, 60)), 0);
        end

        run_b(4, 1);
        run_b(5, 0);
        run_b(5, B_MAX);
        run_b(3, 2);
        run_b(7, 4);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/manta_run_ctrl.md
MANTA_RUN_CTRL -- requirements
Module: manta_run_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 10, number of cycles the core is held at PC 0 before release.
REQ-002 SHALL have parameter MAX_CYCLES, default 1000, run-cycle budget before forced stop.
REQ-003 SHALL have parameter ADDR_W, default 16, instruction-memory address width.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  begin load/run sequence; honoured only in IDLE or DONE.
REQ-007 SHALL have port load_valid  input  1  loader beat valid.
REQ-008 SHALL have port load_ready  output  1  controller accepts beat.
REQ-009 SHALL have port load_data  input  16  instruction word.
REQ-010 SHALL have port load_last  input  1  marks final program word.
REQ-011 SHALL have port imem_we  output  1  instruction-memory write enable.
REQ-012 SHALL have port imem_addr  output  ADDR_W  instruction-memory write address.
REQ-013 SHALL have port imem_wdata  output  16  instruction-memory write data.
REQ-014 SHALL have port core_hold  output  1  forces core PC to 0 and stalls it while high.
REQ-015 SHALL have port core_halt  input  1  core signals program end.
REQ-016 SHALL have ports busy, done, timeout, load_ovf  output  1 each  status flags.
REQ-017 SHALL have port cycle_count  output  32  run cycles elapsed.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, HOLD, RUN, DONE.
REQ-019 IDLE: core_hold=1, load_ready=0; start=1 -> LOAD next cycle, clearing wr_ptr, cycle_count, done, timeout, load_ovf.
REQ-020 LOAD: load_ready=1; a beat transfers when load_valid&&load_ready.
REQ-021 On each transfer, same cycle (combinational): imem_we=1, imem_addr=wr_ptr, imem_wdata=load_data; wr_ptr increments at clock edge.
REQ-022 imem_we SHALL be 0 in every cycle without a transfer.
REQ-023 wr_ptr SHALL wrap from 2^ADDR_W-1 to 0; a transfer at wr_ptr=2^ADDR_W-1 without load_last sets sticky load_ovf.
REQ-024 Transfer with load_last=1 -> HOLD next cycle; load_ready=0 from HOLD onward.
REQ-025 HOLD: core_hold=1 for exactly HOLD_CYCLES cycles, then RUN; HOLD_CYCLES=0 SHALL be treated as 1.
REQ-026 RUN: core_hold=0; cycle_count increments by 1 every RUN cycle.
REQ-027 RUN, core_halt=1 -> DONE next cycle, timeout=0.
REQ-028 RUN, cycle_count reaching MAX_CYCLES (value after increment) without halt -> DONE, timeout=1.
REQ-029 Simultaneous halt and budget exhaustion SHALL take halt path: timeout=0.
REQ-030 DONE: done=1, core_hold=1, cycle_count frozen; start=1 -> LOAD as in REQ-019.
REQ-031 start in LOAD, HOLD or RUN SHALL be ignored.
REQ-032 busy SHALL be 1 in LOAD, HOLD, RUN; 0 otherwise.
REQ-033 cycle_count SHALL saturate at 2^32-1 (reachable only with large MAX_CYCLES).

Reset
REQ-034 rst=1 at a rising edge SHALL force IDLE regardless of state, including mid-LOAD and mid-RUN.
REQ-035 After reset: core_hold=1; load_ready, imem_we, busy, done, timeout, load_ovf=0; imem_addr, wr_ptr, cycle_count=0.
REQ-036 Reset SHALL take priority over start, load beats and core_halt in the same cycle.

Verification
REQ-037 Load 4 words 0x1111..0x4444, last on 4th -> imem writes addr 0..3 in order, HOLD 10 cycles with core_hold=1, then core_hold=0.
REQ-038 RUN, assert core_halt after 25 run cycles -> done=1, timeout=0, cycle_count=25, core_hold=1.
REQ-039 RUN with core_halt never asserted -> after 1000 run cycles done=1, timeout=1, cycle_count=1000.
REQ-040 Toggle load_valid with gaps -> imem_we only on valid cycles, addresses contiguous; start pulses mid-LOAD ignored.
REQ-041 ADDR_W=2, load 5 words, last on 5th -> addresses 0,1,2,3,0; load_ovf=1.
REQ-042 rst during RUN at cycle 7 -> next cycle IDLE, core_hold=1, cycle_count=0; new start repeats full sequence cleanly.
